// File: rtl/stage2_guess_fsm.sv
// Stage-2 number-guessing round: an LFSR-drawn target, lives seeded from the stage-1 bonus,
// and registered verdict/score outputs for the downstream scoring stage.
module stage2_guess_fsm #(
  parameter logic [6:0] LFSR_SEED      = 7'h5A,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter int         BASE_SCORE     = 20,
  parameter int         LIFE_SCORE     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pass1,
  input  logic [1:0] bonus1,
  input  logic [6:0] guess,
  input  logic       guess_valid,
  output logic       busy,
  output logic [6:0] target,
  output logic [2:0] lives,
  output logic [1:0] hint,
  output logic       done,
  output logic       pass2,
  output logic [7:0] score
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BASE_PTS   = 8'(BASE_SCORE);
  localparam logic [7:0] LIFE_PTS   = 8'(LIFE_SCORE);

  state_t     r_state;
  logic [7:0] r_timer;
  logic [6:0] r_lfsr;
  logic       r_busy;
  logic [6:0] r_target;
  logic [2:0] r_lives;
  logic [1:0] r_hint;
  logic       r_done;
  logic       r_pass2;
  logic [7:0] r_score;

  logic [6:0] w_lfsr_next;
  logic       w_hit;
  logic       w_miss;
  logic [1:0] w_hint_miss;
  logic [7:0] w_win_score;

  // x^7+x^6+1 Fibonacci; a nonzero seed keeps it off the all-zero lockup state.
  assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  assign w_hit       = guess_valid && (guess == r_target);
  // A wrong guess preempts the timeout charge in the same cycle.
  assign w_miss      = (guess_valid && !w_hit) || (!guess_valid && (r_timer == TIMER_LAST));
  assign w_hint_miss = !guess_valid ? 2'b11 : ((guess < r_target) ? 2'b01 : 2'b10);
  assign w_win_score = BASE_PTS + LIFE_PTS * {5'd0, r_lives};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= 8'd0;
      r_lfsr   <= LFSR_SEED;
      r_busy   <= 1'b0;
      r_target <= 7'd0;
      r_lives  <= 3'd0;
      r_hint   <= 2'b00;
      r_done   <= 1'b0;
      r_pass2  <= 1'b0;
      r_score  <= 8'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      r_done <= 1'b0;
      r_hint <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pass2 <= 1'b0;
            r_score <= 8'd0;
            if (pass1) begin
              r_state  <= S_PLAY;
              r_busy   <= 1'b1;
              r_lives  <= {1'b0, bonus1} + 3'd1;
              r_target <= r_lfsr;
              r_timer  <= 8'd0;
            end else begin
              r_done  <= 1'b1;
              r_lives <= 3'd0;
            end
          end
        end
        S_PLAY: begin
          if (w_hit) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_target <= 7'd0;
            r_done   <= 1'b1;
            r_pass2  <= 1'b1;
            r_score  <= w_win_score;
            r_timer  <= 8'd0;
          end else if (w_miss) begin
            r_hint  <= w_hint_miss;
            r_timer <= 8'd0;
            if (r_lives <= 3'd1) begin
              r_lives  <= 3'd0;
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_target <= 7'd0;
              r_done   <= 1'b1;
              r_pass2  <= 1'b0;
              r_score  <= 8'd0;
            end else begin
              r_lives <= r_lives - 3'd1;
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign target = r_target;
  assign lives  = r_lives;
  assign hint   = r_hint;
  assign done   = r_done;
  assign pass2  = r_pass2;
  assign score  = r_score;

endmodule

// File: tb/tb_stage2_guess_fsm.sv
// Bench for stage2_guess_fsm: a rule-level round model checked every cycle,
// plus hand-computed literal expectations around each directed scenario.
module tb_stage2_guess_fsm;
  localparam int         TO   = 16;
  localparam int         BASE = 20;
  localparam int         LIFE = 10;
  localparam logic [6:0] SEED = 7'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pass1 = 1'b0;
  logic [1:0] bonus1 = 2'd0;
  logic [6:0] guess = 7'd0;
  logic       guess_valid = 1'b0;
  logic       busy;
  logic [6:0] target;
  logic [2:0] lives;
  logic [1:0] hint;
  logic       done;
  logic       pass2;
  logic [7:0] score;

  stage2_guess_fsm #(
    .LFSR_SEED(SEED), .TIMEOUT_CYCLES(TO), .BASE_SCORE(BASE), .LIFE_SCORE(LIFE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pass1(pass1), .bonus1(bonus1),
    .guess(guess), .guess_valid(guess_valid), .busy(busy), .target(target),
    .lives(lives), .hint, .done(done), .pass2(pass2), .score(score)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round model: target sequence as a table indexed by cycles since reset
  logic [6:0] seq [127];
  int         m_idx = 0;
  bit         m_play = 1'b0;
  int         m_idle = 0;
  int         e_lives = 0;
  int         e_score = 0;
  logic       e_busy = 1'b0, e_done = 1'b0, e_pass2 = 1'b0;
  logic [6:0] e_target = 7'd0;
  logic [1:0] e_hint = 2'b00;
  logic [6:0] m_cur;
  bit         m_miss;

  initial begin
    seq[0] = SEED;
    for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = 0; m_play = 0; m_idle = 0;
      e_lives = 0; e_score = 0; e_busy = 0; e_done = 0; e_pass2 = 0;
      e_target = 0; e_hint = 0;
    end else begin
      m_cur = seq[m_idx];
      m_idx = (m_idx + 1) % 127;
      e_done = 0;
      e_hint = 0;
      if (!m_play) begin
        if (start && !pass1) begin
          e_done = 1; e_pass2 = 0; e_score = 0; e_lives = 0;
        end else if (start) begin
          m_play = 1; e_busy = 1; e_lives = 1 + int'(bonus1); e_target = m_cur;
          m_idle = 0; e_pass2 = 0; e_score = 0;
        end
      end else begin
        m_miss = 0;
        if (guess_valid && guess == e_target) begin
          e_done = 1; e_pass2 = 1; e_score = (BASE + LIFE * e_lives) % 256;
          m_play = 0; e_busy = 0; e_target = 0;
        end else if (guess_valid) begin
          e_hint = (guess < e_target) ? 2'b01 : 2'b10;
          m_miss = 1;
        end else if (m_idle == TO - 1) begin
          e_hint = 2'b11;
          m_miss = 1;
        end else begin
          m_idle++;
        end
        if (m_miss) begin
          m_idle = 0;
          e_lives = (e_lives > 0) ? e_lives - 1 : 0;
          if (e_lives == 0) begin
            e_done = 1; e_pass2 = 0; e_score = 0; m_play = 0; e_busy = 0; e_target = 0;
          end
        end
      end
    end
  end

  // Scoreboard: every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", busy, e_busy);
      check("cyc_target", target, e_target);
      check("cyc_lives", lives, e_lives);
      check("cyc_hint", hint, e_hint);
      check("cyc_done", done, e_done);
      check("cyc_pass2", pass2, e_pass2);
      check("cyc_score", score, e_score);
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic p, input logic [1:0] b);
    start = 1'b1; pass1 = p; bonus1 = b;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_guess(input logic [6:0] g);
    guess = g; guess_valid = 1'b1;
    tick(1);
    guess_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] t;
    cmp_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_lives", lives, 0);
    check("rst_score", score, 0);

    // guess_valid in IDLE produces no hint
    do_guess(7'h10);
    check("idle_guess_hint", hint, 0);
    check("idle_guess_busy", busy, 0);

    // stage 1 failed: immediate lose verdict
    do_start(1'b0, 2'd3);
    check("t1_done", done, 1);
    check("t1_pass2", pass2, 0);
    check("t1_score", score, 0);
    check("t1_busy", busy, 0);
    tick(1);
    check("t1_done_drop", done, 0);

    // first-guess win with 3 lives
    do_start(1'b1, 2'd2);
    check("t2_busy", busy, 1);
    check("t2_lives", lives, 3);
    do_guess(e_target);
    check("t2_done", done, 1);
    check("t2_pass2", pass2, 1);
    check("t2_score", score, 50);
    check("t2_target_clr", target, 0);

    // single life, low guess loses
    do_start(1'b1, 2'd0);
    do_guess(e_target - 7'd1);
    check("t3_hint", hint, 1);
    check("t3_lives", lives, 0);
    check("t3_done", done, 1);
    check("t3_pass2", pass2, 0);
    check("t3_score", score, 0);

    // no guesses: two timeouts
    do_start(1'b1, 2'd1);
    tick(15);
    check("t4_pre_hint", hint, 0);
    check("t4_pre_lives", lives, 2);
    tick(1);
    check("t4_to_hint", hint, 3);
    check("t4_to_lives", lives, 1);
    tick(16);
    check("t4_end_hint", hint, 3);
    check("t4_end_done", done, 1);
    check("t4_end_pass2", pass2, 0);
    check("t4_end_busy", busy, 0);

    // guess collides with the timeout cycle
    do_start(1'b1, 2'd3);
    t = (e_target == 7'h7F) ? 8'd1 : 8'd2;
    do_guess(7'h7F);
    check("t5_high_hint", hint, t);
    check("t5_high_lives", lives, 3);
    tick(15);
    do_guess(7'h00);
    check("t5_coll_hint", hint, 1);
    check("t5_coll_lives", lives, 2);
    tick(15);
    check("t5_restart_hint", hint, 0);
    tick(1);
    check("t5_to_hint", hint, 3);
    check("t5_to_lives", lives, 1);
    do_guess(e_target);
    check("t5_win_score", score, 30);

    // reset mid-PLAY, start ignored in PLAY
    do_start(1'b1, 2'd3);
    do_guess(7'h00);
    do_guess(7'h00);
    check("t6_lives", lives, 2);
    do_start(1'b1, 2'd0);
    check("t6_restart_ignored", lives, 2);
    check("t6_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_target", target, 0);
    check("t6_rst_lives", lives, 0);
    check("t6_rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(1'b1, 2'd0);
    check("t6_seed_target", target, 7'h5A);
    check("t6_new_lives", lives, 1);
    do_guess(e_target);
    check("t6_win_score", score, 30);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
